anti_rebond: RTL and testbench

ANTI_REBOND -- requirements
Module: anti_rebond

---
 rtl/anti_rebond_pkg.sv | 19 +
 rtl/anti_rebond_synchroniseur.sv | 24 ++
 rtl/anti_rebond.sv | 142 ++++++++++++++
 tb/tb_anti_rebond.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/anti_rebond_pkg.sv
// Shared types and default timing for the anti_rebond push-button debouncer.
package anti_rebond_pkg;

    typedef enum logic [1:0] {
        REPOS          = 2'd0,
        FILTRE_APPUI   = 2'd1,
        APPUYE         = 2'd2,
        FILTRE_RELACHE = 2'd3
    } etat_t;

    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int REPEAT_DELAY_DEF    = 50_000_000;
    localparam int REPEAT_PERIOD_DEF   = 10_000_000;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/anti_rebond_synchroniseur.sv
// Two-flop synchronizer bringing the raw button level into the clk domain.
module synchroniseur (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/anti_rebond.sv
// Push-button debouncer with press/release pulses; optional auto-repeat on hold
// enabled by defining ANTI_REBOND_REPEAT_EN.
module anti_rebond
    import anti_rebond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic etat,
    output logic impulse,
    output logic relache
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             btn_s;
    etat_t            state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             etat_reg, impulse_reg, relache_reg;
    logic             press_evt, release_evt, rep_pulse;

    synchroniseur u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn),
        .q   (btn_s)
    );

    // The filter counter is only ever cleared or incremented below CNT_LAST,
    // so it cannot wrap.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        press_evt   = 1'b0;
        release_evt = 1'b0;
        case (state_reg)
            REPOS: begin
                if (btn_s) begin
                    state_next = FILTRE_APPUI;
                    cnt_next   = '0;
                end
            end
            FILTRE_APPUI: begin
                if (!btn_s) begin
                    state_next = REPOS;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = APPUYE;
                    press_evt  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            APPUYE: begin
                if (!btn_s) begin
                    state_next = FILTRE_RELACHE;
                    cnt_next   = '0;
                end
            end
            FILTRE_RELACHE: begin
                if (btn_s) begin
                    state_next = APPUYE;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next  = REPOS;
                    release_evt = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = REPOS;
                cnt_next   = '0;
            end
        endcase
    end

`ifdef ANTI_REBOND_REPEAT_EN
    localparam int REP_W = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    logic [REP_W-1:0] rep_reg, rep_next;
    logic             rep_first_reg, rep_first_next;

    // Counts only while staying in APPUYE; any other transition restarts the
    // delay phase so a bounce back into APPUYE waits the full delay again.
    always_comb begin
        rep_next       = rep_reg;
        rep_first_next = rep_first_reg;
        rep_pulse      = 1'b0;
        if (state_reg == APPUYE && state_next == APPUYE) begin
            if (rep_reg == (rep_first_reg ? DELAY_LAST : PERIOD_LAST)) begin
                rep_pulse      = 1'b1;
                rep_next       = '0;
                rep_first_next = 1'b0;
            end else begin
                rep_next = rep_reg + 1'b1;
            end
        end else begin
            rep_next       = '0;
            rep_first_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rep_reg       <= '0;
            rep_first_reg <= 1'b1;
        end else begin
            rep_reg       <= rep_next;
            rep_first_reg <= rep_first_next;
        end
    end
`else
    assign rep_pulse = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= REPOS;
            cnt_reg     <= '0;
            etat_reg    <= 1'b0;
            impulse_reg <= 1'b0;
            relache_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            etat_reg    <= (state_next == APPUYE) || (state_next == FILTRE_RELACHE);
            impulse_reg <= press_evt | rep_pulse;
            relache_reg <= release_evt;
        end
    end

    assign etat    = etat_reg;
    assign impulse = impulse_reg;
    assign relache = relache_reg;

endmodule

// File: tb/tb_anti_rebond.sv
// Scoreboard bench for anti_rebond: a run-length reference model predicts pulses
// and level; a monitor checks them. Auto-repeat checks follow ANTI_REBOND_REPEAT_EN.
module tb_anti_rebond;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn = 1'b0;
    logic etat, impulse, relache;

    always #5 clk = ~clk;

    anti_rebond #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn     (btn),
        .etat    (etat),
        .impulse (impulse),
        .relache (relache)
    );

    typedef struct {
        int kind;   // 1 = impulse, 2 = relache
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    bit  hist[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  cyc   = 0;
    bit  exp_etat = 1'b0;
    bit  lvl  = 1'b0;
    int  run  = 0;
    int  hold = 0;

    // Reference: the synchronized level lags btn by two samples; the accepted
    // level flips after D+1 consecutive samples that disagree with it.
    task automatic model_step();
        bit  bs;
        ev_t e;
        cyc++;
        if (!rst) begin
            hist = {1'b0, 1'b0};
            lvl = 1'b0; run = 0; hold = 0; exp_etat = 1'b0;
            return;
        end
        bs = hist.pop_front();
        hist.push_back(btn);
        if (bs != lvl) begin
            run++;
            hold = 0;
            if (run == D + 1) begin
                lvl = bs;
                run = 0;
                e.kind = lvl ? 1 : 2;
                e.cyc  = cyc;
                exp_q.push_back(e);
            end
        end else begin
            if (lvl && run == 0) begin
                hold++;
`ifdef ANTI_REBOND_REPEAT_EN
                if (hold == RD || (hold > RD && (hold - RD) % RP == 0)) begin
                    e.kind = 1;
                    e.cyc  = cyc;
                    exp_q.push_back(e);
                end
`endif
            end else begin
                hold = 0;
            end
            run = 0;
        end
        exp_etat = lvl;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    task automatic check_outputs();
        ev_t e;
        int  got;
        n_vec++;
        if (etat !== exp_etat) begin
            n_err++;
            $display("FAIL etat cycle %0d: got %b expected %b", cyc, etat, exp_etat);
        end
        n_vec++;
        if ((impulse & relache) !== 1'b0) begin
            n_err++;
            $display("FAIL exclusive cycle %0d: got impulse=%b relache=%b expected not both 1", cyc, impulse, relache);
        end
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            n_vec++; n_err++;
            $display("FAIL missed_pulse: got none expected kind %0d at cycle %0d", e.kind, e.cyc);
        end
        if (impulse === 1'b1 || relache === 1'b1) begin
            got = (impulse === 1'b1) ? 1 : 2;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pulse cycle %0d: got kind %0d expected none", cyc, got);
            end else begin
                e = exp_q.pop_front();
                if (e.kind != got || e.cyc != cyc) begin
                    n_err++;
                    $display("FAIL pulse: got kind %0d at cycle %0d expected kind %0d at cycle %0d", got, cyc, e.kind, e.cyc);
                end else begin
                    $display("pulse %s at cycle %0d ok", (got == 1) ? "impulse" : "relache", cyc);
                end
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            n_vec++; n_err++;
            $display("FAIL missed_pulse: got none expected kind %0d at cycle %0d", e.kind, e.cyc);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            check_outputs();
        end
    end

    task automatic drive(input bit v, input int n);
        repeat (n) begin
            @(negedge clk);
            #1 btn = v;
        end
    endtask

    task automatic check_zero(input string tag);
        n_vec++;
        if ({etat, impulse, relache} !== 3'b000) begin
            n_err++;
            $display("FAIL %s: got etat/impulse/relache=%b expected 000", tag, {etat, impulse, relache});
        end
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        #1 rst = 1'b0;
        #1 check_zero(tag);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        #1 check_zero("reset_state");
        drive(1'b0, 3);
        @(negedge clk);
        #1 rst = 1'b1;
        drive(1'b0, 8);

        // clean press, then clean release
        drive(1'b1, 20);
        drive(1'b0, 15);
        // bounce on press
        drive(1'b1, 1); drive(1'b0, 1); drive(1'b1, 1); drive(1'b0, 1);
        drive(1'b1, 14);
        // release with a two-cycle high glitch during the filter
        drive(1'b0, 2); drive(1'b1, 2); drive(1'b0, 15);
        // long hold (auto-repeat when enabled)
        drive(1'b1, 30);
        drive(1'b0, 15);
        // reset mid press filter, button kept high
        drive(1'b1, 4);
        pulse_reset("reset_mid_filter");
        drive(1'b1, 12);
        // reset while pressed
        pulse_reset("reset_while_pressed");
        drive(1'b1, 15);
        drive(1'b0, 15);

        for (int i = 0; i < 70; i++) begin
            bit v;
            int n;
            v = 1'($urandom_range(0, 1));
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 25)) : int'($urandom_range(1, 4));
            drive(v, n);
        end

        drive(1'b0, 25);
        @(negedge clk);
        #2;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected pulses, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
